ysyx_22041207_mem_responder: RTL and testbench
==============================================

YSYX_22041207_MEM_RESPONDER -- requirements
Module: ysyx_22041207_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, giving the number of 64-bit backing-store words.
REQ-002 The block SHALL have parameter BASE, default 64'h8000_0000, giving the byte address of word 0.
REQ-003 The block SHALL have parameter LATENCY, default 2, legal range 0..15, giving the number of added wait cycles before each response.
REQ-004 The ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  reset, asynchronous and active-high
- w_valid_i  in  1  write request valid
- w_ready_o  out  1  write request accepted
- w_addr_i  in  64  write byte address
- w_data_i  in  64  write data, lane-aligned
- w_mask_i  in  8  write byte enables; bit n enables byte lane n
- w_valid_o  out  1  write complete
- w_ready_i  in  1  initiator accepts write completion
- rx_r_valid_i  in  1  read request valid
- rx_r_ready_o  out  1  read request accepted
- rx_r_addr_i  in  64  read byte address
- rx_r_size_i  in  8  read size; captured, not used for data
- rx_data_read_o  out  64  read data: the full aligned doubleword
- rx_data_valid  out  1  read data valid
- rx_data_ready  in  1  initiator accepts read data
- resp_err  out  1  out-of-range flag; present only under YSYX_22041207_MEM_RESP_ERR_EN

Function
REQ-005 The block SHALL use an FSM with states IDLE, W_WAIT, W_RESP, R_WAIT and R_RESP.
REQ-006 w_ready_o SHALL be combinational: (state==IDLE) && w_valid_i.
REQ-007 rx_r_ready_o SHALL be combinational: (state==IDLE) && rx_r_valid_i && !w_valid_i, so a write wins a same-cycle conflict.
REQ-008 On a write handshake edge the block SHALL capture the address, data and mask, load the wait counter with LATENCY, and enter W_WAIT.
REQ-009 On a read handshake edge the block SHALL capture the address and size, load the wait counter with LATENCY, and enter R_WAIT.
REQ-010 In a wait state the counter SHALL decrement each cycle; at zero the state SHALL move to the RESP state, so the response valid is first high LATENCY+1 cycles after the handshake edge.
REQ-011 The masked write to the backing store SHALL occur on the edge that enters W_RESP; unmasked bytes SHALL be unchanged.
REQ-012 The read word SHALL be registered into rx_data_read_o on the edge that enters R_RESP.
REQ-013 The word index SHALL be (addr-BASE)>>3; addr[2:0] SHALL be ignored for indexing.
REQ-014 An address is in range iff BASE <= addr < BASE+DEPTH*8.
REQ-015 An out-of-range write SHALL be dropped and still completed; an out-of-range read SHALL return 0.
REQ-016 w_valid_o SHALL be high exactly in W_RESP, and rx_data_valid SHALL be high exactly in R_RESP; the response SHALL be held until w_ready_i or rx_data_ready is sampled high, and the state SHALL then return to IDLE.
REQ-017 rx_data_read_o SHALL stay stable while rx_data_valid is high.
REQ-018 Only one transaction SHALL be outstanding at a time; requests arriving while busy SHALL receive no ready until IDLE.
REQ-019 The earliest next acceptance SHALL be the cycle after the completion edge.
REQ-020 A read of a word SHALL return data written by any earlier completed write to that word.

Reset
REQ-021 While rst=1, the state SHALL be forced to IDLE immediately, regardless of clk.
REQ-022 While rst=1, the counter, w_valid_o, rx_data_valid, rx_data_read_o and resp_err SHALL be 0.
REQ-023 The backing store SHALL NOT be reset.
REQ-024 Reset asserted mid-transaction SHALL abort it, and no store write SHALL occur after that reset.

Configuration
REQ-025 With YSYX_22041207_MEM_RESP_ERR_EN defined, resp_err SHALL be registered alongside the response valid, equal 1 iff the captured address was out of range, and be 0 outside RESP states.
REQ-026 Without YSYX_22041207_MEM_RESP_ERR_EN, the resp_err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 LATENCY=2: write 0x80000008, data 0x1122334455667788, mask 0xFF; then read 0x80000008 -> w_valid_o first high 3 cycles after the write handshake; read returns 0x1122334455667788.
REQ-028 Write 0x80000008, data 0xAAAA_0000_0000_0000, mask 0xC0 over the previous word -> read returns 0xAAAA334455667788.
REQ-029 w_valid_i and rx_r_valid_i rise in the same IDLE cycle -> w_ready_o=1 and rx_r_ready_o=0; the read is accepted the cycle after write completion.
REQ-030 rx_data_ready held low 5 cycles -> rx_data_valid and data stay constant for 5 cycles, then drop 1 cycle after rx_data_ready=1.
REQ-031 Read 0x7FFF_FFF8 with ERR_EN defined -> data 0 and resp_err=1 with rx_data_valid.
REQ-032 Assert rst during W_WAIT -> outputs 0 at once; a later read of the target word returns the old value.

Source files
------------

// File: rtl/ysyx_22041207_mem_responder.sv
// Single-outstanding memory responder: one write or read at a time, LATENCY wait cycles, then a held response.
// Optional out-of-range flag resp_err is enabled by defining YSYX_22041207_MEM_RESP_ERR_EN.
module ysyx_22041207_mem_responder #(
    parameter int          DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        w_valid_i,
    output logic        w_ready_o,
    input  logic [63:0] w_addr_i,
    input  logic [63:0] w_data_i,
    input  logic [7:0]  w_mask_i,
    output logic        w_valid_o,
    input  logic        w_ready_i,
    input  logic        rx_r_valid_i,
    output logic        rx_r_ready_o,
    input  logic [63:0] rx_r_addr_i,
    input  logic [7:0]  rx_r_size_i,
    output logic [63:0] rx_data_read_o,
    output logic        rx_data_valid,
    input  logic        rx_data_ready
`ifdef YSYX_22041207_MEM_RESP_ERR_EN
    ,
    output logic        resp_err
`endif
);

    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;

    typedef enum logic [2:0] {
        IDLE,
        W_WAIT,
        W_RESP,
        R_WAIT,
        R_RESP
    } state_t;

    state_t state, state_next;

    logic [3:0]  cnt;
    logic [63:0] addr_q;
    logic [63:0] data_q;
    logic [7:0]  mask_q;
    logic [7:0]  size_q;
    logic [63:0] mem [DEPTH];

    logic [63:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          wait_done;
    logic          unused_bits;

    // Decode works on the captured address so it is stable for the whole transaction.
    assign off       = addr_q - BASE;
    assign in_range  = (addr_q >= BASE) && (off < SPAN);
    assign idx       = off[AW+2:3];
    assign wait_done = (cnt == 4'd0);

    // Size is captured for the initiator's benefit only; low offset bits select a lane, not a word.
    assign unused_bits = ^{size_q, off[63:AW+3], off[2:0]};

    assign w_ready_o     = (state == IDLE) && w_valid_i;
    assign rx_r_ready_o  = (state == IDLE) && rx_r_valid_i && !w_valid_i;
    assign w_valid_o     = (state == W_RESP);
    assign rx_data_valid = (state == R_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (w_valid_i) begin
                    state_next = W_WAIT;
                end else if (rx_r_valid_i) begin
                    state_next = R_WAIT;
                end
            end
            W_WAIT: if (wait_done) state_next = W_RESP;
            W_RESP: if (w_ready_i) state_next = IDLE;
            R_WAIT: if (wait_done) state_next = R_RESP;
            R_RESP: if (rx_data_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= 4'd0;
            addr_q         <= 64'd0;
            data_q         <= 64'd0;
            mask_q         <= 8'd0;
            size_q         <= 8'd0;
            rx_data_read_o <= 64'd0;
        end else begin
            if (w_ready_o) begin
                addr_q <= w_addr_i;
                data_q <= w_data_i;
                mask_q <= w_mask_i;
                cnt    <= 4'(LATENCY);
            end else if (rx_r_ready_o) begin
                addr_q <= rx_r_addr_i;
                size_q <= rx_r_size_i;
                cnt    <= 4'(LATENCY);
            end else if ((state == W_WAIT || state == R_WAIT) && !wait_done) begin
                cnt <= cnt - 4'd1;
            end

            if (state == R_WAIT && wait_done) begin
                rx_data_read_o <= in_range ? mem[idx] : 64'd0;
            end
        end
    end

    // No reset here on purpose: the store keeps its contents; the write is gated by state, which reset clears.
    always_ff @(posedge clk) begin
        if (state == W_WAIT && wait_done && in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (mask_q[i]) begin
                    mem[idx][8*i +: 8] <= data_q[8*i +: 8];
                end
            end
        end
    end

`ifdef YSYX_22041207_MEM_RESP_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_err <= 1'b0;
        end else begin
            resp_err <= ((state_next == W_RESP) || (state_next == R_RESP)) && !in_range;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22041207_mem_responder.sv
// Scoreboarded bench for ysyx_22041207_mem_responder: directed cases plus random traffic against a word-map model.
module tb_ysyx_22041207_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          LAT   = 2;

    logic        clk;
    logic        rst;
    logic        w_valid_i;
    logic        w_ready_o;
    logic [63:0] w_addr_i;
    logic [63:0] w_data_i;
    logic [7:0]  w_mask_i;
    logic        w_valid_o;
    logic        w_ready_i;
    logic        rx_r_valid_i;
    logic        rx_r_ready_o;
    logic [63:0] rx_r_addr_i;
    logic [7:0]  rx_r_size_i;
    logic [63:0] rx_data_read_o;
    logic        rx_data_valid;
    logic        rx_data_ready;
`ifdef YSYX_22041207_MEM_RESP_ERR_EN
    logic        resp_err;
`endif

    ysyx_22041207_mem_responder #(
        .DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_addr_i(w_addr_i),
        .w_data_i(w_data_i), .w_mask_i(w_mask_i), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .rx_r_valid_i(rx_r_valid_i), .rx_r_ready_o(rx_r_ready_o), .rx_r_addr_i(rx_r_addr_i),
        .rx_r_size_i(rx_r_size_i), .rx_data_read_o(rx_data_read_o),
        .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready)
`ifdef YSYX_22041207_MEM_RESP_ERR_EN
        , .resp_err(resp_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: sparse map of word index -> 64-bit contents.
    logic [63:0] model [longint];

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;
    exp_t rq[$];
    logic cur_err;

    function automatic bit in_rng(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'(DEPTH) * 64'd8);
    endfunction

    function automatic longint word_of(input logic [63:0] a);
        return longint'((a - BASE) / 64'd8);
    endfunction

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        if (!in_rng(a)) return 64'd0;
        if (!model.exists(word_of(a))) return 64'd0;
        return model[word_of(a)];
    endfunction

    task automatic ref_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
        logic [63:0] w;
        if (!in_rng(a)) return;
        w = model.exists(word_of(a)) ? model[word_of(a)] : 64'd0;
        for (int i = 0; i < 8; i++)
            if (m[i]) w[8*i +: 8] = d[8*i +: 8];
        model[word_of(a)] = w;
    endtask

    // Monitor: pop on each new read response, then require the data to hold while valid.
    logic        prev_v = 1'b0;
    logic [63:0] held;
    exp_t        e;
    always @(negedge clk) begin
        if (rx_data_valid) begin
            if (!prev_v) begin
                if (rq.size() == 0) begin
                    check("rd_unexpected", 64'(rq.size()), 64'd1);
                end else begin
                    e = rq.pop_front();
                    check("rd_data", rx_data_read_o, e.data);
`ifdef YSYX_22041207_MEM_RESP_ERR_EN
                    check("rd_err", 64'(resp_err), 64'(e.err));
`endif
                end
                held = rx_data_read_o;
            end else begin
                check("rd_stable", rx_data_read_o, held);
            end
        end
        prev_v = rx_data_valid;
    end

    task automatic finish_write(input int hold);
        int cyc = 0;
        do begin @(negedge clk); cyc++; end while (!w_valid_o && cyc < 64);
        check("w_latency", 64'(cyc - 1), 64'(LAT + 1));
`ifdef YSYX_22041207_MEM_RESP_ERR_EN
        check("w_err", 64'(resp_err), 64'(cur_err));
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("w_hold", 64'(w_valid_o), 64'd1);
        end
        w_ready_i = 1'b1;
        @(posedge clk); #1 w_ready_i = 1'b0;
        @(negedge clk);
        check("w_drop", 64'(w_valid_o), 64'd0);
    endtask

    task automatic finish_read(input int hold);
        int cyc = 0;
        do begin @(negedge clk); cyc++; end while (!rx_data_valid && cyc < 64);
        check("r_latency", 64'(cyc - 1), 64'(LAT + 1));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("r_hold", 64'(rx_data_valid), 64'd1);
        end
        rx_data_ready = 1'b1;
        @(posedge clk); #1 rx_data_ready = 1'b0;
        @(negedge clk);
        check("r_drop", 64'(rx_data_valid), 64'd0);
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m, input int hold);
        int n = 0;
        @(posedge clk); #1;
        w_valid_i = 1'b1; w_addr_i = a; w_data_i = d; w_mask_i = m;
        ref_write(a, d, m);
        cur_err = !in_rng(a);
        @(negedge clk);
        while (!w_ready_o && n < 64) begin @(negedge clk); n++; end
        check("w_accept", 64'(w_ready_o), 64'd1);
        @(posedge clk); #1 w_valid_i = 1'b0;
        finish_write(hold);
    endtask

    task automatic do_read(input logic [63:0] a, input int hold);
        int n = 0;
        @(posedge clk); #1;
        rx_r_valid_i = 1'b1; rx_r_addr_i = a; rx_r_size_i = 8'($urandom);
        rq.push_back('{ref_read(a), !in_rng(a)});
        @(negedge clk);
        while (!rx_r_ready_o && n < 64) begin @(negedge clk); n++; end
        check("r_accept", 64'(rx_r_ready_o), 64'd1);
        @(posedge clk); #1 rx_r_valid_i = 1'b0;
        finish_read(hold);
    endtask

    initial begin
        logic [63:0] a, d;
        logic [7:0]  m;
        int          n;
        longint      picks [7];

        rst = 1'b1;
        w_valid_i = 0; w_addr_i = 0; w_data_i = 0; w_mask_i = 0; w_ready_i = 0;
        rx_r_valid_i = 0; rx_r_addr_i = 0; rx_r_size_i = 0; rx_data_ready = 0;
        cur_err = 0;
        repeat (3) @(negedge clk);
        check("rst_w_valid", 64'(w_valid_o), 64'd0);
        check("rst_r_valid", 64'(rx_data_valid), 64'd0);
        check("rst_r_data", rx_data_read_o, 64'd0);
`ifdef YSYX_22041207_MEM_RESP_ERR_EN
        check("rst_err", 64'(resp_err), 64'd0);
`endif
        rst = 1'b0;

        // Basic write/read and a partial-mask overlay.
        do_write(BASE + 64'h8, 64'h1122_3344_5566_7788, 8'hFF, 0);
        do_read(BASE + 64'h8, 1);
        do_write(BASE + 64'h8, 64'hAAAA_0000_0000_0000, 8'hC0, 2);
        do_read(BASE + 64'h8, 0);

        // Edges of the window and low address bits ignored for indexing.
        do_write(BASE + 64'(DEPTH - 1) * 8, 64'hDEAD_BEEF_0123_4567, 8'hFF, 1);
        do_read(BASE + 64'(DEPTH - 1) * 8 + 64'd7, 0);
        do_write(BASE + 64'd3, 64'h0F0F_0F0F_F0F0_F0F0, 8'hFF, 0);
        do_read(BASE + 64'd5, 0);

        // Out-of-range accesses: writes dropped but completed, reads give zero.
        do_write(BASE - 64'd8, 64'h5555_5555_5555_5555, 8'hFF, 0);
        do_write(BASE + 64'(DEPTH) * 8, 64'h6666_6666_6666_6666, 8'hFF, 1);
        do_read(64'h7FFF_FFF8, 0);
        do_read(BASE + 64'(DEPTH) * 8, 1);

        // Same-cycle write and read: write wins, read waits for completion.
        @(posedge clk); #1;
        a = BASE + 64'h10; d = 64'hCAFE_F00D_1234_5678;
        w_valid_i = 1; w_addr_i = a; w_data_i = d; w_mask_i = 8'hFF;
        rx_r_valid_i = 1; rx_r_addr_i = a; rx_r_size_i = 8'd3;
        ref_write(a, d, 8'hFF);
        rq.push_back('{ref_read(a), 1'b0});
        @(negedge clk);
        check("conflict_w_ready", 64'(w_ready_o), 64'd1);
        check("conflict_r_ready", 64'(rx_r_ready_o), 64'd0);
        @(posedge clk); #1 w_valid_i = 0;
        n = 0;
        do begin
            @(negedge clk); n++;
            check("busy_r_ready", 64'(rx_r_ready_o), 64'd0);
        end while (!w_valid_o && n < 64);
        check("conflict_w_resp", 64'(w_valid_o), 64'd1);
        w_ready_i = 1;
        @(posedge clk); #1 w_ready_i = 0;
        @(negedge clk);
        check("r_accept_after_w", 64'(rx_r_ready_o), 64'd1);
        @(posedge clk); #1 rx_r_valid_i = 0;
        finish_read(0);

        // Backpressure on read data for five cycles.
        do_read(BASE + 64'h8, 5);

        // Reset in the middle of a write wait: abort, outputs clear, store untouched.
        @(posedge clk); #1;
        w_valid_i = 1; w_addr_i = BASE + 64'h8; w_data_i = 64'hFFFF_0000_FFFF_0000; w_mask_i = 8'hFF;
        @(negedge clk);
        check("rstmid_w_ready", 64'(w_ready_o), 64'd1);
        @(posedge clk); #1 w_valid_i = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_w_valid", 64'(w_valid_o), 64'd0);
        check("rstmid_r_valid", 64'(rx_data_valid), 64'd0);
        check("rstmid_r_data", rx_data_read_o, 64'd0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        do_read(BASE + 64'h8, 0);

        // Random traffic over a small pool of words plus out-of-range addresses.
        picks = '{0, 1, 2, 3, 5, 17, DEPTH - 1};
        for (int t = 0; t < 60; t++) begin
            n = int'($urandom_range(0, 8));
            if (n < 7) a = BASE + 64'(picks[n]) * 8 + 64'($urandom_range(0, 7));
            else if (n == 7) a = BASE - 64'd8 * 64'($urandom_range(1, 4));
            else a = BASE + 64'(DEPTH) * 8 + 64'd8 * 64'($urandom_range(0, 3));
            d = {$urandom, $urandom};
            m = (in_rng(a) && !model.exists(word_of(a))) ? 8'hFF : 8'($urandom);
            if ($urandom_range(0, 1) == 0 || (in_rng(a) && !model.exists(word_of(a))))
                do_write(a, d, m, int'($urandom_range(0, 3)));
            else
                do_read(a, int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        check("rq_drained", 64'(rq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
